// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   bcd_digit_t    : one packed BCD digit
//   state_t        : converter FSM states
//   BCD_ADJ_THRESH : digit value at or above which the add-3 adjust applies
//   BCD_ADJ_ADD    : adjust amount applied before each shift
//   SEG_BLANK      : active-low 7-segment pattern for a blanked digit,
//                    used downstream together with blank_mask
//                    (BIN2BCD_BLANK_EN builds)
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;
  localparam logic [6:0] SEG_BLANK      = 7'b1111111;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle between a binary source and bin_to_bcd_seq.
//   start, bin_in         : request and operand (source -> converter)
//   busy, done            : conversion status (converter -> source)
//   bcd_out, overflow     : registered result (converter -> source)
//   blank_mask            : leading-zero blanking mask, present only when
//                           BIN2BCD_BLANK_EN is defined
// master = binary source side, slave = converter side.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);

  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0]     blank_mask;
`endif

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out,
`ifdef BIN2BCD_BLANK_EN
    input  blank_mask,
`endif
    input  overflow
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out,
`ifdef BIN2BCD_BLANK_EN
    output blank_mask,
`endif
    output overflow
  );

endinterface

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit adjust: adds 3 when the digit is 5 or
// more, so that the following left shift carries correctly into the next
// decimal digit. 4-bit in, 4-bit out, no carry between digits.
//   d_in  : BCD digit before adjust
//   d_out : adjusted digit
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t d_in,
  output bcd_digit_t d_out
);

  assign d_out = (d_in >= BCD_ADJ_THRESH) ? (d_in + BCD_ADJ_ADD) : d_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bin_to_bcd_seq_if slave (start/bin_in in; busy/done/bcd_out/
//           overflow out; blank_mask out when BIN2BCD_BLANK_EN is defined)
// Optional feature macro: BIN2BCD_BLANK_EN adds the registered blank_mask.
//
// state | meaning
// IDLE  | waiting for start; operand is latched on acceptance
// SHIFT | one adjust+shift per cycle, BIN_W cycles
// DONE  | result visible, done pulses for this single cycle
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  bin_to_bcd_seq_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic               acc_q, acc_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_next;
  logic [BIN_W-1:0]   shift_next;
  logic               carry_out;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_adj
    bcd_add3 u_add3 (
      .d_in  (work_q[4*g +: 4]),
      .d_out (work_adj[4*g +: 4])
    );
  end

  assign work_next  = {work_adj[BCD_W-2:0], shift_q[BIN_W-1]};
  assign carry_out  = work_adj[BCD_W-1];
  assign shift_next = shift_q << 1;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d, blank_next;

  // Bit i set when digit i and every digit above it are zero; bit 0 stays 0.
  always_comb begin : blank_calc
    logic all_zero;
    all_zero   = 1'b1;
    blank_next = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero      = all_zero & (work_next[4*i +: 4] == 4'd0);
      blank_next[i] = all_zero;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    work_d  = work_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
`ifdef BIN2BCD_BLANK_EN
    blank_d = blank_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d = bus.bin_in;
          work_d  = '0;
          acc_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_next;
        work_d  = work_next;
        acc_d   = acc_q | carry_out;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Result registers load on the last shift so they are already
          // valid in the DONE cycle, alongside the done pulse.
          bcd_d   = work_next;
          ovf_d   = acc_q | carry_out;
`ifdef BIN2BCD_BLANK_EN
          blank_d = blank_next;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      work_q  <= '0;
      acc_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
`ifdef BIN2BCD_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = (state_q == DONE);
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;
`ifdef BIN2BCD_BLANK_EN
  assign bus.blank_mask = blank_q;
`endif

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock. It produces the packed BCD digits that feed the team's per-digit BCD-to-7-segment display decoders. It sits between a binary source (counter, switches, ALU result) and the HEX display path. A start/busy/done handshake moves each conversion through the block.

Parameters:
BIN_W, 8, width of binary input; legal range 1..16
DIGITS, 3, number of BCD output digits; legal range 1..5

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request; sampled only in IDLE
bin_in  input  BIN_W  binary value; captured in the cycle start is accepted
busy  output  1  high from the cycle after acceptance until the cycle done is high
done  output  1  one-cycle pulse when bcd_out and overflow update
bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0]
overflow  output  1  value exceeded 10^DIGITS-1; registered together with bcd_out

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, busy=0, done=0, bcd_out=0, overflow=0. Internal shift and BCD registers and the counter are cleared.
- Asserting rst_n low mid-conversion aborts immediately. There is no done pulse, and bcd_out returns to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Latch bin_in into the shift register.
  - Clear the BCD working register and the overflow accumulator.
  - Set cnt=BIN_W. Go to SHIFT.
- IDLE, start=0: stay.
- SHIFT, each cycle:
  - For every digit, if digit>=5, add 3 (combinational, 4-bit, no carry between digits).
  - Shift {bcd_work, bin_shift} left by 1.
  - Any 1 shifted out of the top digit sets the sticky overflow accumulator.
  - Decrement cnt. When cnt reaches 1 in this cycle (last shift), go to DONE.
- DONE: bcd_out<=bcd_work, overflow<=accumulator, done=1 for this cycle only. Go to IDLE.
- Latency: start accepted at cycle T. done=1 at cycle T+BIN_W+1, with bcd_out valid from that same cycle.
- Minimum start-to-start period is BIN_W+2 cycles.
- start while busy or in DONE is ignored, with no queueing. bin_in changes after acceptance have no effect.
- bcd_out and overflow hold their last result until the next DONE.
- On overflow, bcd_out holds the low DIGITS digits of the true decimal value (modulo 10^DIGITS).
- Each output digit is always in 0..9. The add-3 stage never yields a digit >9 after the shift.
- busy = (state != IDLE) && (state != DONE).
- bin_in=0 gives bcd_out=0 and overflow=0.

Optional Feature:
Macro BIN2BCD_BLANK_EN.
- Defined:
  - Adds output port blank_mask, DIGITS bits wide, registered in DONE alongside bcd_out.
  - Bit i is 1 when digit i and every digit above it are zero. Bit 0 is always 0, so the ones digit is never blanked.
  - Display logic uses it to force segments off (7'b1111111).
  - Reset value is all zeros.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package bcd_pkg holds:
  - typedef bcd_digit_t (4-bit)
  - state enum (IDLE/SHIFT/DONE)
  - constant BCD_ADJ_THRESH=5
  - constant BCD_ADJ_ADD=3
  - the blank-segment constant 7'b1111111
- Sub-module bcd_add3: combinational per-digit adjust (in 4 bits, out 4 bits), instantiated DIGITS times via generate.

Test Plan:
- Reset, then start with bin_in=8'd0: done at T+9, bcd_out=12'h000, overflow=0. With BIN2BCD_BLANK_EN, blank_mask=3'b110.
- bin_in=8'd255: bcd_out=12'h255, overflow=0, done exactly one cycle, busy high for cycles T+1..T+8.
- bin_in=8'd99, with start pulsed again at T+3 and bin_in=8'd7: second start ignored, bcd_out=12'h099. A fresh start at T+10 with 8'd7 gives 12'h007.
- DIGITS=2, bin_in=8'd123: bcd_out=8'h23, overflow=1. A following conversion of 8'd42 gives 8'h42, overflow=0.
- rst_n asserted at T+4 mid-conversion: outputs immediately go to 0. No done pulse. A subsequent start of 8'd128 gives 12'h128.
- Exhaustive sweep 0..255 back-to-back at the minimum period: every result matches the decimal reference, and every digit is <=9.
